// File: rtl/cpu_step_pkg.sv
// Shared types and constants for the run/step/halt processor clock controller.
package cpu_step_pkg;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } step_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sw_debounce.sv
// Switch conditioner: multi-flop synchroniser followed by a stability filter.
module sw_debounce
  import cpu_step_pkg::*;
#(
  parameter int DEB_CYCLES = 3
) (
  input  logic clk_2,
  input  logic reset,
  input  logic sw,
  output logic sw_filt
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      sw_filt <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
      // Count consecutive disagreeing cycles; any agreement restarts the count.
      if (synced != sw_filt) begin
        if (cnt_q == CNT_LAST) begin
          sw_filt <= synced;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run/step/halt controller producing a one-cycle processor clock-enable,
// with divided free-run, single-step, PC breakpoint and a pulse counter.
module cpu_step_ctrl
  import cpu_step_pkg::*;
#(
  parameter int NBITS_PC   = 8,
  parameter int CNT_BITS   = 8,
  parameter int DIV        = 4,
  parameter int DEB_CYCLES = 3
) (
  input  logic                clk_2,
  input  logic                reset,
  input  logic                run_sw,
  input  logic                step_sw,
  input  logic                bkpt_en,
  input  logic [NBITS_PC-1:0] bkpt_addr,
  input  logic [NBITS_PC-1:0] pc,
  output logic                cpu_en,
  output logic [CNT_BITS-1:0] cycle_cnt,
  output logic [1:0]          state,
  output logic                bkpt_hit
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  step_state_t   cur_q, nxt;
  logic [DW-1:0] div_q, div_d;
  logic          first_q, first_d;
  logic          en_d, hit_d;
  logic          run_f, step_f, step_prev_q, step_req, due;

  sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run_deb (
    .clk_2  (clk_2),
    .reset  (reset),
    .sw     (run_sw),
    .sw_filt(run_f)
  );

  sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
    .clk_2  (clk_2),
    .reset  (reset),
    .sw     (step_sw),
    .sw_filt(step_f)
  );

  assign step_req = step_f & ~step_prev_q;
  assign due      = (div_q == DIV_LAST);
  assign state    = cur_q;

  always_comb begin
    nxt     = cur_q;
    en_d    = 1'b0;
    div_d   = div_q;
    first_d = first_q;
    hit_d   = bkpt_hit;
    case (cur_q)
      RUN: begin
        // Run release outranks both the breakpoint and a due pulse.
        if (!run_f) begin
          nxt = HALT;
        end else if (due && bkpt_en && (pc == bkpt_addr) && !first_q) begin
          nxt   = HALT;
          hit_d = 1'b1;
        end else begin
          div_d = due ? '0 : div_q + 1'b1;
          if (due) begin
            en_d    = 1'b1;
            first_d = 1'b0;
          end
        end
      end
      STEP: nxt = HALT;
      default: begin
        // HALT, and the unused encoding, arm the divider for the next RUN entry.
        div_d   = '0;
        first_d = 1'b1;
        if (run_f) begin
          nxt   = RUN;
          hit_d = 1'b0;
        end else if (step_req) begin
          nxt   = STEP;
          en_d  = 1'b1;
          hit_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      cur_q       <= HALT;
      div_q       <= '0;
      first_q     <= 1'b1;
      cpu_en      <= 1'b0;
      cycle_cnt   <= '0;
      bkpt_hit    <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      cur_q       <= nxt;
      div_q       <= div_d;
      first_q     <= first_d;
      cpu_en      <= en_d;
      cycle_cnt   <= cycle_cnt + CNT_BITS'(en_d);
      bkpt_hit    <= hit_d;
      step_prev_q <= step_f;
    end
  end

endmodule

// File: doc/cpu_step_ctrl.md
# cpu_step_ctrl

Run/step/halt controller for the board's processor datapath. It turns the slow board clock and two switch inputs into a one-cycle processor clock-enable `cpu_en`, which supports free-run at a divided rate, single-step and a PC breakpoint. It also keeps a cycle counter for the LCD panel. It sits between the SWI inputs and the datapath that drives `lcd_pc`, `lcd_instruction` and related signals.

## Interface
- `NBITS_PC`, default 8: width of the `pc` and `bkpt_addr` inputs.
- `CNT_BITS`, default 8: width of `cycle_cnt`.
- `DIV`, default 4: board-clock cycles per `cpu_en` pulse in RUN; legal range is 1..256.
- `DEB_CYCLES`, default 3: consecutive stable cycles needed before a switch change is accepted; must be at least 1.

Ports (name, direction, width, meaning):
- `clk_2`, input, 1: the only clock. All state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `run_sw`, input, 1: raw switch; level 1 requests RUN.
- `step_sw`, input, 1: raw switch; each accepted rising edge requests one step.
- `bkpt_en`, input, 1: enables the breakpoint compare.
- `bkpt_addr`, input, NBITS_PC: breakpoint address.
- `pc`, input, NBITS_PC: current PC from the datapath.
- `cpu_en`, output, 1: registered clock-enable pulse to the datapath.
- `cycle_cnt`, output, CNT_BITS: number of `cpu_en` pulses issued, modulo 2^CNT_BITS.
- `state`, output, 2: current state, for LEDs.
- `bkpt_hit`, output, 1: sticky breakpoint flag.

## Operation
- **Input conditioning.** Each raw switch passes through a 2-flop synchroniser and then a debounce filter.
  - The filtered value takes the synchronised value only after the synchronised value has differed from it for DEB_CYCLES consecutive cycles.
  - Any reversal before then restarts the count.
  - A step request is one cycle on which filtered `step_sw` goes from 0 to 1.
- **States.** HALT=0, RUN=1, STEP=2. Encoding 3 is unused and decodes to HALT.
- **HALT.**
  - If filtered run is 1, go to RUN. Run has priority over a simultaneous step request.
  - Otherwise, a step request goes to STEP.
  - Leaving HALT clears `bkpt_hit`.
- **STEP.**
  - `cpu_en`=1 for exactly that one cycle; the next state is always HALT.
  - The breakpoint is not checked in STEP, so a step is always allowed from a breakpoint.
- **RUN.**
  - The divider counts 0..DIV-1, wraps to 0, and is cleared on entry.
  - A pulse is due when the divider equals DIV-1.
  - A due pulse is issued (`cpu_en`=1 next cycle) unless the breakpoint fires.
  - Breakpoint fires when `bkpt_en`=1 and `pc`==`bkpt_addr` on a due pulse, except for the first due pulse after entering RUN. This lets the processor run off a breakpoint.
  - When it fires: no pulse, go to HALT, set `bkpt_hit`=1.
  - Filtered run falling to 0 goes to HALT. If this coincides with a due pulse, halting wins and no pulse is issued.
  - Step requests are ignored in RUN.
- **Counter.** `cycle_cnt` increments in the same cycle as each `cpu_en`=1 and wraps from 2^CNT_BITS-1 to 0.
- **Reset.** Mid-operation reset immediately clears everything, including a pulse in flight.

## Timing
- Reset values: state=HALT, `cpu_en`=0, `cycle_cnt`=0, `bkpt_hit`=0, divider=0. Synchroniser and filter registers reset to 0, so a switch held high through reset is seen as a rising edge after release.
- Switch latency: a raw edge held stable appears on the filtered value DEB_CYCLES+2 edges later.
  - Step: `cpu_en` is high during the following cycle, so raw edge to `cpu_en` is DEB_CYCLES+3 cycles.
  - Run: RUN is entered one edge after the filtered change.
- RUN pulse rate: one `cpu_en` every DIV cycles. The first pulse comes DIV cycles after entering RUN. With DIV=1, `cpu_en` is high every cycle.
- `cpu_en` is never high in two consecutive cycles unless DIV=1.
- `pc` is sampled in the due cycle. The datapath updates `pc` on the edge at which `cpu_en` is high.

## Structure
- Package `cpu_step_pkg` holds:
  - typedef `step_state_t`, a 2-bit enum: HALT, RUN, STEP;
  - constant `SYNC_STAGES`=2.
- Sub-module `sw_debounce`, with parameter DEB_CYCLES, contains the synchroniser and filter. It is instantiated twice, once for run and once for step.
- The FSM, divider and counter live in `cpu_step_ctrl`.

## Test plan
All scenarios use defaults: DIV=4, DEB_CYCLES=3.
1. **Reset.** Assert `reset` mid-RUN with `cycle_cnt`=5. Outputs clear asynchronously: `cpu_en`=0, `cycle_cnt`=0, state=0. After release, no pulse occurs while switches are held low.
2. **Single step.** Raise `step_sw` with 1-cycle glitches, then hold it. Exactly one `cpu_en` pulse occurs, 6 cycles after the stable edge; `cycle_cnt` goes 0 to 1; state goes 2 then 0. Holding for 100 cycles gives no further pulse.
3. **Free run.** `run_sw`=1 for 40 cycles after acceptance gives pulses every 4 cycles and `cycle_cnt`=10. Dropping `run_sw` exactly on a due cycle gives no pulse that cycle; state=0.
4. **Breakpoint.** Set `bkpt_addr`=0x12, `bkpt_en`=1, and have `pc` increment on each pulse from 0x10.
   - Pulses occur at pc=0x10 and 0x11, then halt with `bkpt_hit`=1.
   - A step then issues a pulse and clears `bkpt_hit`.
   - Re-entering RUN at pc=0x12 issues its first pulse normally.
5. **Wrap.** CNT_BITS=8 with 257 pulses gives `cycle_cnt`=1.
6. **Priority.** Run and step accepted in the same cycle from HALT: RUN is entered; no STEP pulse; the first pulse comes 4 cycles later.
